sprite_bouncer_n: RTL and testbench



---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_bouncer_n_if.sv | 40 ++++
 rtl/sprite_axis_step.sv | 47 ++++
 rtl/sprite_bouncer_n.sv | 177 +++++++++++++++++
 tb/tb_sprite_bouncer_n.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion engine.
package sprite_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPD    = 2'd1,
        S_COLL   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Guard bits added above COORD_W so p + v can go negative or past LIM without wrapping.
    localparam int ARITH_EXTRA = 2;

    function automatic int pair_count(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/sprite_bouncer_n_if.sv
// Load port, frame tick and committed-frame outputs of sprite_bouncer_n.
interface sprite_bouncer_n_if
    import sprite_pkg::*;
#(
    parameter int N_SPR   = 4,
    parameter int COORD_W = 10,
    parameter int VEL_W   = 4
);
    localparam int IW = $clog2(N_SPR);

    // Load handshake: a load transfers on a clock edge where ld_valid && ld_ready;
    // ld_ready never depends on ld_valid, and the loader may hold or drop ld_valid freely.
    logic                        animate;
    logic                        ld_valid;
    logic                        ld_ready;
    logic [IW-1:0]               ld_idx;
    logic [COORD_W-1:0]          ld_x;
    logic [COORD_W-1:0]          ld_y;
    logic signed [VEL_W-1:0]     ld_vx;
    logic signed [VEL_W-1:0]     ld_vy;
    logic [N_SPR*COORD_W-1:0]    o_x;
    logic [N_SPR*COORD_W-1:0]    o_y;
    logic [N_SPR-1:0]            o_wall;
    logic [N_SPR-1:0]            o_collide;
    logic                        busy;
    logic                        done;
    logic                        overrun;
    state_t                      dbg_state;

    modport master (
        output animate, ld_valid, ld_idx, ld_x, ld_y, ld_vx, ld_vy,
        input  ld_ready, o_x, o_y, o_wall, o_collide, busy, done, overrun, dbg_state
    );

    modport slave (
        input  animate, ld_valid, ld_idx, ld_x, ld_y, ld_vx, ld_vy,
        output ld_ready, o_x, o_y, o_wall, o_collide, busy, done, overrun, dbg_state
    );

endinterface

// File: rtl/sprite_axis_step.sv
// Combinational one-axis bounce: advance p by v and reflect off the [H_SIZE, LIM-1-H_SIZE] band.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int VEL_W   = 4,
    parameter int LIM     = 640,
    parameter int H_SIZE  = 16
) (
    input  logic [COORD_W-1:0]      p,
    input  logic signed [VEL_W-1:0] v,
    output logic [COORD_W-1:0]      p_n,
    output logic signed [VEL_W-1:0] v_n,
    output logic                    hit
);
    localparam int AW = COORD_W + ARITH_EXTRA;
    localparam logic signed [AW-1:0] LO = AW'(H_SIZE);
    localparam logic signed [AW-1:0] HI = AW'(LIM - 1 - H_SIZE);

    logic signed [AW-1:0]    nxt;
    logic signed [VEL_W-1:0] v_neg;

    assign nxt = $signed({{ARITH_EXTRA{1'b0}}, p}) + $signed({{(AW-VEL_W){v[VEL_W-1]}}, v});

    // The most-negative velocity has no positive twin; clamp it to +max.
    assign v_neg = (v == {1'b1, {(VEL_W-1){1'b0}}}) ? {1'b0, {(VEL_W-1){1'b1}}} : -v;

    always_comb begin
        p_n = p;
        v_n = v;
        hit = 1'b0;
        if (v != '0) begin
            if (nxt < LO) begin
                p_n = COORD_W'(H_SIZE);
                v_n = v_neg;
                hit = 1'b1;
            end else if (nxt > HI) begin
                p_n = COORD_W'(LIM - 1 - H_SIZE);
                v_n = v_neg;
                hit = 1'b1;
            end else begin
                p_n = nxt[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_bouncer_n.sv
// Time-multiplexed bouncing-sprite motion engine with double-buffered positions.
// Optional pairwise collision pass enabled by defining SPRITE_COLLISION_EN.
module sprite_bouncer_n
    import sprite_pkg::*;
#(
    parameter int N_SPR    = 4,
    parameter int COORD_W  = 10,
    parameter int VEL_W    = 4,
    parameter int H_SIZE   = 16,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480
) (
    input logic               clk,
    input logic               rst,
    sprite_bouncer_n_if.slave s
);
    localparam int IW = $clog2(N_SPR);

    state_t                   state, state_n;
    logic [IW-1:0]            idx;
    logic [COORD_W-1:0]       wx [N_SPR];
    logic [COORD_W-1:0]       wy [N_SPR];
    logic signed [VEL_W-1:0]  wvx [N_SPR];
    logic signed [VEL_W-1:0]  wvy [N_SPR];
    logic [N_SPR-1:0]         acc_wall;
    logic [N_SPR*COORD_W-1:0] cx, cy;
    logic [N_SPR-1:0]         c_wall;
    logic                     done_q, overrun_q;
    logic                     last_spr;

    logic [COORD_W-1:0]       nx, ny;
    logic signed [VEL_W-1:0]  nvx, nvy;
    logic                     hx, hy;

    sprite_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W), .LIM(D_WIDTH), .H_SIZE(H_SIZE)) u_step_x (
        .p(wx[idx]), .v(wvx[idx]), .p_n(nx), .v_n(nvx), .hit(hx)
    );

    sprite_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W), .LIM(D_HEIGHT), .H_SIZE(H_SIZE)) u_step_y (
        .p(wy[idx]), .v(wvy[idx]), .p_n(ny), .v_n(nvy), .hit(hy)
    );

    assign last_spr = (idx == IW'(N_SPR - 1));

`ifdef SPRITE_COLLISION_EN
    localparam int NPAIR = pair_count(N_SPR);
    localparam int PCW   = $clog2(NPAIR + 1);

    logic [IW-1:0]      pi, pj;
    logic [PCW-1:0]     pc;
    logic [N_SPR-1:0]   acc_coll, c_coll;
    logic [COORD_W-1:0] dx, dy;
    logic               overlap, last_pair;

    assign dx        = (wx[pi] > wx[pj]) ? (wx[pi] - wx[pj]) : (wx[pj] - wx[pi]);
    assign dy        = (wy[pi] > wy[pj]) ? (wy[pi] - wy[pj]) : (wy[pj] - wy[pi]);
    assign overlap   = (int'(dx) < 2 * H_SIZE) && (int'(dy) < 2 * H_SIZE);
    assign last_pair = (pc == PCW'(NPAIR - 1));
    assign s.o_collide = c_coll;
`else
    assign s.o_collide = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (s.animate) state_n = S_UPD;
            S_UPD: begin
                if (last_spr) begin
`ifdef SPRITE_COLLISION_EN
                    state_n = S_COLL;
`else
                    state_n = S_COMMIT;
`endif
                end
            end
`ifdef SPRITE_COLLISION_EN
            S_COLL:   if (last_pair) state_n = S_COMMIT;
`endif
            S_COMMIT: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_SPR; k++) begin
                wx[k]  <= COORD_W'(H_SIZE + k * (2 * H_SIZE + 1));
                wy[k]  <= COORD_W'(D_HEIGHT / 2);
                wvx[k] <= VEL_W'(1);
                wvy[k] <= (k % 2 == 0) ? VEL_W'(1) : {VEL_W{1'b1}};
                cx[k*COORD_W +: COORD_W] <= COORD_W'(H_SIZE + k * (2 * H_SIZE + 1));
                cy[k*COORD_W +: COORD_W] <= COORD_W'(D_HEIGHT / 2);
            end
            idx       <= '0;
            acc_wall  <= '0;
            c_wall    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SPRITE_COLLISION_EN
            pi <= '0; pj <= IW'(1); pc <= '0;
            acc_coll <= '0;
            c_coll   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state != S_IDLE && s.animate) overrun_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (s.animate) begin
                        idx      <= '0;
                        acc_wall <= '0;
`ifdef SPRITE_COLLISION_EN
                        pi <= '0; pj <= IW'(1); pc <= '0;
                        acc_coll <= '0;
`endif
                    end else if (s.ld_valid && int'(s.ld_idx) < N_SPR) begin
                        wx[s.ld_idx]  <= s.ld_x;
                        wy[s.ld_idx]  <= s.ld_y;
                        wvx[s.ld_idx] <= s.ld_vx;
                        wvy[s.ld_idx] <= s.ld_vy;
                    end
                end
                S_UPD: begin
                    wx[idx]       <= nx;
                    wy[idx]       <= ny;
                    wvx[idx]      <= nvx;
                    wvy[idx]      <= nvy;
                    acc_wall[idx] <= hx | hy;
                    idx           <= idx + IW'(1);
                end
`ifdef SPRITE_COLLISION_EN
                S_COLL: begin
                    if (overlap) begin
                        acc_coll[pi] <= 1'b1;
                        acc_coll[pj] <= 1'b1;
                    end
                    if (pj == IW'(N_SPR - 1)) begin
                        pi <= pi + IW'(1);
                        pj <= IW'(int'(pi) + 2);
                    end else begin
                        pj <= pj + IW'(1);
                    end
                    pc <= pc + PCW'(1);
                end
`endif
                S_COMMIT: begin
                    for (int k = 0; k < N_SPR; k++) begin
                        cx[k*COORD_W +: COORD_W] <= wx[k];
                        cy[k*COORD_W +: COORD_W] <= wy[k];
                    end
                    c_wall <= acc_wall;
`ifdef SPRITE_COLLISION_EN
                    c_coll <= acc_coll;
`endif
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign s.ld_ready  = (state == S_IDLE) && !s.animate;
    assign s.o_x       = cx;
    assign s.o_y       = cy;
    assign s.o_wall    = c_wall;
    assign s.busy      = (state != S_IDLE);
    assign s.done      = done_q;
    assign s.overrun   = overrun_q;
    assign s.dbg_state = state;

endmodule

// File: tb/tb_sprite_bouncer_n.sv
// Self-checking bench for sprite_bouncer_n against a plain-integer motion model.
// Collision expectations follow SPRITE_COLLISION_EN.
module tb_sprite_bouncer_n;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int VW = 4;
    localparam int H  = 16;
    localparam int W  = 640;
    localparam int HT = 480;
`ifdef SPRITE_COLLISION_EN
    localparam int NPAIR = N * (N - 1) / 2;
`else
    localparam int NPAIR = 0;
`endif
    localparam int SB_W = 2 * N * CW + 2 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_bouncer_n_if #(.N_SPR(N), .COORD_W(CW), .VEL_W(VW)) bus ();

    sprite_bouncer_n #(
        .N_SPR(N), .COORD_W(CW), .VEL_W(VW), .H_SIZE(H), .D_WIDTH(W), .D_HEIGHT(HT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: working state in plain ints, expected committed frames in a queue.
    int mx [N], my [N], mvx [N], mvy [N];
    logic [SB_W-1:0] exp_q [$];

    function automatic logic [N*CW-1:0] pack_pos(input int a [N]);
        logic [N*CW-1:0] r;
        for (int k = 0; k < N; k++) r[k*CW +: CW] = CW'(a[k]);
        return r;
    endfunction

    function automatic int neg_sat(input int v);
        if (v == -(1 << (VW - 1))) return (1 << (VW - 1)) - 1;
        return -v;
    endfunction

    function automatic void axis_ref(inout int p, inout int v, input int lim, output bit hit);
        int nxt;
        hit = 1'b0;
        if (v == 0) return;
        nxt = p + v;
        if (nxt < H) begin
            p = H; v = neg_sat(v); hit = 1'b1;
        end else if (nxt > lim - 1 - H) begin
            p = lim - 1 - H; v = neg_sat(v); hit = 1'b1;
        end else begin
            p = nxt;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k]  = H + k * (2 * H + 1);
            my[k]  = HT / 2;
            mvx[k] = 1;
            mvy[k] = (k % 2 == 0) ? 1 : -1;
        end
        exp_q.delete();
    endfunction

    function automatic void model_pass();
        logic [N-1:0] wall, coll;
        bit hx, hy;
        int p, v;
        wall = '0;
        coll = '0;
        for (int k = 0; k < N; k++) begin
            p = mx[k]; v = mvx[k]; axis_ref(p, v, W, hx);  mx[k] = p; mvx[k] = v;
            p = my[k]; v = mvy[k]; axis_ref(p, v, HT, hy); my[k] = p; mvy[k] = v;
            wall[k] = hx | hy;
        end
`ifdef SPRITE_COLLISION_EN
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                int ax, ay;
                ax = (mx[i] > mx[j]) ? mx[i] - mx[j] : mx[j] - mx[i];
                ay = (my[i] > my[j]) ? my[i] - my[j] : my[j] - my[i];
                if (ax < 2 * H && ay < 2 * H) begin
                    coll[i] = 1'b1;
                    coll[j] = 1'b1;
                end
            end
`endif
        exp_q.push_back({pack_pos(mx), pack_pos(my), wall, coll});
    endfunction

    task automatic do_load(input int idx, input int x, input int y, input int vx, input int vy);
        int waited = 0;
        while (!bus.ld_ready && waited < 50) begin
            @(posedge clk); #1; waited++;
        end
        if (!bus.ld_ready) check("ld_ready_timeout", 0, 1);
        bus.ld_valid = 1'b1;
        bus.ld_idx   = 2'(idx);
        bus.ld_x     = CW'(x);
        bus.ld_y     = CW'(y);
        bus.ld_vx    = VW'(vx);
        bus.ld_vy    = VW'(vy);
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        mx[idx] = x; my[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
    endtask

    // One animate pass; extra_at > 0 re-pulses animate before that edge of the pass.
    task automatic run_pass(input int extra_at);
        int lat = 0;
        bit got_done = 1'b0;
        logic [SB_W-1:0] e;
        logic [N*CW-1:0] held_x;
        bus.animate = 1'b1;
        @(posedge clk); #1;
        bus.animate  = 1'b0;
        bus.ld_valid = 1'b0;
        model_pass();
        check("busy_start", bus.busy, 1);
        while (!got_done && lat < 200) begin
            bus.animate = (lat + 1 == extra_at);
            @(posedge clk); #1;
            bus.animate = 1'b0;
            lat++;
            if (bus.done) got_done = 1'b1;
        end
        e = exp_q.pop_front();
        if (!got_done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency",   lat, N + 1 + NPAIR);
            check("o_x",       bus.o_x,       e[SB_W-1 -: N*CW]);
            check("o_y",       bus.o_y,       e[2*N + N*CW - 1 -: N*CW]);
            check("o_wall",    bus.o_wall,    e[2*N-1 -: N]);
            check("o_collide", bus.o_collide, e[N-1:0]);
            check("busy_at_done", bus.busy, 0);
            held_x = bus.o_x;
            @(posedge clk); #1;
            check("done_pulse", bus.done, 0);
            check("o_x_held",   bus.o_x, held_x);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_o_x"},     bus.o_x,       pack_pos(mx));
        check({tag, "_o_y"},     bus.o_y,       pack_pos(my));
        check({tag, "_wall"},    bus.o_wall,    0);
        check({tag, "_coll"},    bus.o_collide, 0);
        check({tag, "_busy"},    bus.busy,      0);
        check({tag, "_done"},    bus.done,      0);
        check({tag, "_overrun"}, bus.overrun,   0);
        check({tag, "_ready"},   bus.ld_ready,  1);
    endtask

    initial begin
        logic [N*CW-1:0] rst_x;
        rst          = 1'b1;
        bus.animate  = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_idx   = '0;
        bus.ld_x     = '0;
        bus.ld_y     = '0;
        bus.ld_vx    = '0;
        bus.ld_vy    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset frame: independently written constants for N=4, H=16.
        rst_x = {10'd115, 10'd82, 10'd49, 10'd16};
        check("rst_o_x_const", bus.o_x, rst_x);
        check_reset_state("rst");

        // Right-wall bounce, then travel back.
        do_load(2, 620, 240, 5, 1);
        run_pass(0);
        check("x2_bounce", bus.o_x[2*CW +: CW], 623);
        check("wall2", bus.o_wall[2], 1);
        run_pass(0);
        check("x2_back", bus.o_x[2*CW +: CW], 618);

        // Left-wall bounce.
        do_load(0, 18, 240, -3, 1);
        run_pass(0);
        check("x0_bounce", bus.o_x[CW-1:0], 16);
        check("wall0", bus.o_wall[0], 1);

        // Stationary overlapping pair.
        model_reset();
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        do_load(0, 100, 100, 0, 0);
        do_load(1, 120, 110, 0, 0);
        run_pass(0);
`ifdef SPRITE_COLLISION_EN
        check("coll_pair", bus.o_collide, 4'b0011);
`else
        check("coll_pair", bus.o_collide, 4'b0000);
`endif

        // Most-negative velocity into the left wall saturates to +max.
        do_load(3, 20, 200, -8, 0);
        run_pass(0);
        run_pass(0);
        check("x3_sat", bus.o_x[3*CW +: CW], 16 + 7);

        // Animate while busy: pass unaffected, overrun sticks.
        check("overrun_pre", bus.overrun, 0);
        run_pass(2);
        check("overrun_set", bus.overrun, 1);
        run_pass(0);
        check("overrun_sticky", bus.overrun, 1);

        // Randomized loads and passes.
        for (int it = 0; it < 24; it++) begin
            int nl;
            nl = $urandom_range(0, 2);
            for (int l = 0; l < nl; l++)
                do_load($urandom_range(0, N - 1), $urandom_range(0, W - 1), $urandom_range(0, HT - 1),
                        int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
            run_pass(0);
        end

        // Reset while UPD is on sprite 1.
        bus.animate = 1'b1;
        @(posedge clk); #1 bus.animate = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        check_reset_state("abort");
        @(posedge clk); #1;
        check("abort_no_done", bus.done, 0);

        // Load and animate together: pass starts, load dropped.
        bus.ld_valid = 1'b1;
        bus.ld_idx   = 2'd1;
        bus.ld_x     = 10'd300;
        bus.ld_y     = 10'd300;
        bus.ld_vx    = 4'sd2;
        bus.ld_vy    = 4'sd2;
        bus.animate  = 1'b1;
        #1;
        check("ready_vs_animate", bus.ld_ready, 0);
        run_pass(0);
        check("x1_no_load", bus.o_x[CW +: CW], 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
